s_seq_div_r4: RTL

- Iterative signed two's-complement divider; the inverse operation of the team's signed array/Dadda multipliers.
- Computes a 2N-bit dividend divided by an N-bit divisor, giving a 2N-bit quotient and an N-bit remainder.
- Uses restoring division on magnitudes, one quotient bit per clock, with sign fix-up at the end.
- Sits beside the combinational multipliers as the sequential arithmetic unit, with valid/ready handshakes on both sides.

---
 rtl/s_seq_div_r4.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/s_seq_div_r4.sv
// Iterative signed divider: 2N-bit dividend / N-bit divisor, restoring radix-2 on magnitudes.
// Optional macro S_SEQ_DIV_ZERO_BYPASS_EN short-cuts the divide-by-zero and overflow cases.
module s_seq_div_r4 #(
   parameter int unsigned N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2*N-1:0]   dividend_i,
   input  logic [N-1:0]     divisor_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [2*N-1:0]   quotient_o,
   output logic [N-1:0]     remainder_o,
   output logic             div_zero_o,
   output logic             overflow_o
);

   localparam int unsigned W  = 2 * N;
   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    dvd_q, dvd_d;     // dividend magnitude, shifts out as quotient shifts in
   logic [N:0]      dsr_q, dsr_d;
   logic [N-1:0]    prem_q, prem_d;
   logic            sq_q, sq_d, sr_q, sr_d;
   logic            dz_q, dz_d, ovf_q, ovf_d;
   logic [N-1:0]    dzrem_q, dzrem_d;
   logic [W-1:0]    quot_q, quot_d;
   logic [N-1:0]    rem_q, rem_d;
   logic            dzo_q, dzo_d, ovfo_q, ovfo_d;

   logic [W-1:0]    dvd_abs;
   logic [N:0]      dsr_abs;
   logic            dz_det, ovf_det;
   logic [N:0]      shifted;
   logic [N+1:0]    diff;
   logic [W-1:0]    q_fix;
   logic [N-1:0]    r_fix;

   always_comb begin
      dvd_abs = dividend_i[W-1] ? -dividend_i : dividend_i;
      dsr_abs = {1'b0, (divisor_i[N-1] ? -divisor_i : divisor_i)};
      dz_det  = (divisor_i == '0);
      ovf_det = (dividend_i == {1'b1, {(W-1){1'b0}}}) && (divisor_i == {N{1'b1}});
      shifted = {prem_q, dvd_q[W-1]};
      diff    = {1'b0, shifted} - {1'b0, dsr_q};
      if (dz_q) begin
         q_fix = '1;
         r_fix = dzrem_q;
      end else if (ovf_q) begin
         q_fix = {1'b1, {(W-1){1'b0}}};
         r_fix = '0;
      end else begin
         q_fix = sq_q ? -dvd_q : dvd_q;
         r_fix = sr_q ? -prem_q : prem_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      dzrem_d = dzrem_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dzo_d   = dzo_q;
      ovfo_d  = ovfo_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               dvd_d   = dvd_abs;
               dsr_d   = dsr_abs;
               prem_d  = '0;
               sq_d    = dividend_i[W-1] ^ divisor_i[N-1];
               sr_d    = dividend_i[W-1];
               dz_d    = dz_det;
               ovf_d   = ovf_det;
               dzrem_d = dividend_i[N-1:0];
               cnt_d   = CW'(W - 1);
               state_d = StCalc;
`ifdef S_SEQ_DIV_ZERO_BYPASS_EN
               if (dz_det) begin
                  quot_d  = '1;
                  rem_d   = dividend_i[N-1:0];
                  dzo_d   = 1'b1;
                  state_d = StDone;
               end else if (ovf_det) begin
                  state_d = StFix;
               end
`endif
            end
         end
         StCalc: begin
            // Keep the difference when the trial subtract does not go negative.
            if (!diff[N+1]) begin
               prem_d = diff[N-1:0];
               dvd_d  = {dvd_q[W-2:0], 1'b1};
            end else begin
               prem_d = shifted[N-1:0];
               dvd_d  = {dvd_q[W-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = StFix;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StFix: begin
            quot_d  = q_fix;
            rem_d   = r_fix;
            dzo_d   = dz_q;
            ovfo_d  = ovf_q;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready_i) begin
               quot_d  = '0;
               rem_d   = '0;
               dzo_d   = 1'b0;
               ovfo_d  = 1'b0;
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         dzrem_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dzo_q   <= 1'b0;
         ovfo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         dzrem_q <= dzrem_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dzo_q   <= dzo_d;
         ovfo_q  <= ovfo_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = dzo_q;
   assign overflow_o  = ovfo_q;

endmodule
